// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath and its sequencer:
// sequencer state encoding and index/address width helpers.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_STREAM    = 3'd2,
        S_DRAIN     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    // Index width that never collapses to zero bits for a size of 1.
    function automatic int max1clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_width(input int rows, input int cols);
        return max1clog2(rows * cols);
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Row-major (row, col) walker over a ROWS x COLS matrix with linear address
// and a flag marking the final element.
module mat_index_counter
    import matmul_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 3,
    localparam int RW = max1clog2(ROWS),
    localparam int CW = max1clog2(COLS),
    localparam int AW = idx_width(ROWS, COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/matmul_seq_driver.sv
// Command-driven sequencer: streams A/B operands from RAM into matrix_mult as
// tagged elements and writes the tagged C result stream into a result RAM.
module matmul_seq_driver
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M = 4,
    parameter int N = 2,
    parameter int K = 3,
    localparam int MW  = max1clog2(M),
    localparam int NW  = max1clog2(N),
    localparam int KW  = max1clog2(K),
    localparam int AAW = idx_width(M, K),
    localparam int BAW = idx_width(K, N),
    localparam int CAW = idx_width(M, N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // cmd handshake: a command is taken on any edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_valid elsewhere is simply ignored.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  a_rd_en,
    output logic [AAW-1:0]        a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  b_rd_en,
    output logic [BAW-1:0]        b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  mm_start,
    output logic [DATA_WIDTH-1:0] mm_a_data,
    output logic [MW-1:0]         mm_a_row,
    output logic [KW-1:0]         mm_a_col,
    output logic                  mm_a_valid,
    output logic [DATA_WIDTH-1:0] mm_b_data,
    output logic [KW-1:0]         mm_b_row,
    output logic [NW-1:0]         mm_b_col,
    output logic                  mm_b_valid,
    input  logic [DATA_WIDTH-1:0] mm_c_data,
    input  logic [MW-1:0]         mm_c_row,
    input  logic [NW-1:0]         mm_c_col,
    input  logic                  mm_c_valid,
    input  logic                  mm_done,
    output logic                  c_wr_en,
    output logic [CAW-1:0]        c_wr_addr,
    output logic [DATA_WIDTH-1:0] c_wr_data,
    output state_t                dbg_state
);

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   a_fin_q, a_fin_d, b_fin_q, b_fin_d;
    logic   cnt_clr, a_last, b_last;

    logic [MW-1:0]  a_row;
    logic [KW-1:0]  a_col;
    logic [AAW-1:0] a_addr;
    logic [KW-1:0]  b_row;
    logic [NW-1:0]  b_col;
    logic [BAW-1:0] b_addr;

    logic                  mm_a_valid_q, mm_a_valid_d, mm_b_valid_q, mm_b_valid_d;
    logic [MW-1:0]         mm_a_row_q, mm_a_row_d;
    logic [KW-1:0]         mm_a_col_q, mm_a_col_d, mm_b_row_q, mm_b_row_d;
    logic [NW-1:0]         mm_b_col_q, mm_b_col_d;
    logic                  c_wr_en_q, c_wr_en_d;
    logic [CAW-1:0]        c_wr_addr_q, c_wr_addr_d;
    logic [DATA_WIDTH-1:0] c_wr_data_q, c_wr_data_d;

    mat_index_counter #(.ROWS(M), .COLS(K)) u_a_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(a_rd_en),
        .row(a_row), .col(a_col), .addr(a_addr), .last(a_last)
    );

    mat_index_counter #(.ROWS(K), .COLS(N)) u_b_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(b_rd_en),
        .row(b_row), .col(b_col), .addr(b_addr), .last(b_last)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        a_fin_d  = a_fin_q;
        b_fin_d  = b_fin_q;
        cnt_clr  = 1'b0;
        mm_start = 1'b0;
        done     = 1'b0;
        a_rd_en  = 1'b0;
        b_rd_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                mm_start = 1'b1;
                cnt_clr  = 1'b1;
                a_fin_d  = 1'b0;
                b_fin_d  = 1'b0;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                a_rd_en = !a_fin_q;
                b_rd_en = !b_fin_q;
                if (a_rd_en && a_last) a_fin_d = 1'b1;
                if (b_rd_en && b_last) b_fin_d = 1'b1;
                // Exit on the registered flags so the last read's data still
                // has the DRAIN cycle to emerge.
                if (a_fin_q && b_fin_q) state_d = S_DRAIN;
            end
            S_DRAIN:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (mm_done) state_d = S_FIN;
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (mm_done && (state_q == S_START || state_q == S_STREAM || state_q == S_DRAIN))
            err_d = 1'b1;
    end

    always_comb begin
        mm_a_valid_d = a_rd_en;
        mm_a_row_d   = a_row;
        mm_a_col_d   = a_col;
        mm_b_valid_d = b_rd_en;
        mm_b_row_d   = b_row;
        mm_b_col_d   = b_col;
        c_wr_en_d    = mm_c_valid && (state_q != S_IDLE);
        c_wr_addr_d  = c_wr_addr_q;
        c_wr_data_d  = c_wr_data_q;
        if (c_wr_en_d) begin
            c_wr_addr_d = CAW'(mm_c_row) * CAW'(N) + CAW'(mm_c_col);
            c_wr_data_d = mm_c_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            err_q        <= 1'b0;
            a_fin_q      <= 1'b0;
            b_fin_q      <= 1'b0;
            mm_a_valid_q <= 1'b0;
            mm_a_row_q   <= '0;
            mm_a_col_q   <= '0;
            mm_b_valid_q <= 1'b0;
            mm_b_row_q   <= '0;
            mm_b_col_q   <= '0;
            c_wr_en_q    <= 1'b0;
            c_wr_addr_q  <= '0;
            c_wr_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            a_fin_q      <= a_fin_d;
            b_fin_q      <= b_fin_d;
            mm_a_valid_q <= mm_a_valid_d;
            mm_a_row_q   <= mm_a_row_d;
            mm_a_col_q   <= mm_a_col_d;
            mm_b_valid_q <= mm_b_valid_d;
            mm_b_row_q   <= mm_b_row_d;
            mm_b_col_q   <= mm_b_col_d;
            c_wr_en_q    <= c_wr_en_d;
            c_wr_addr_q  <= c_wr_addr_d;
            c_wr_data_q  <= c_wr_data_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && rst_n;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign a_rd_addr  = a_addr;
    assign b_rd_addr  = b_addr;
    assign mm_a_data  = a_rd_data;
    assign mm_a_row   = mm_a_row_q;
    assign mm_a_col   = mm_a_col_q;
    assign mm_a_valid = mm_a_valid_q;
    assign mm_b_data  = b_rd_data;
    assign mm_b_row   = mm_b_row_q;
    assign mm_b_col   = mm_b_col_q;
    assign mm_b_valid = mm_b_valid_q;
    assign c_wr_en    = c_wr_en_q;
    assign c_wr_addr  = c_wr_addr_q;
    assign c_wr_data  = c_wr_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_matmul_seq_driver.sv
// Directed bench for matmul_seq_driver: operand/result RAM models plus a small
// Q8.8 matrix_mult responder driven from the scenario tasks.
module tb_matmul_seq_driver;
    import matmul_pkg::*;

    localparam int DW = 16, M = 4, N = 2, K = 3;
    localparam int MW = 2, NW = 1, KW = 2, AAW = 4, BAW = 3, CAW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, busy, done, err;
    logic a_rd_en, b_rd_en, mm_start, mm_a_valid, mm_b_valid, c_wr_en;
    logic [AAW-1:0] a_rd_addr;
    logic [BAW-1:0] b_rd_addr;
    logic [DW-1:0]  a_rd_data = '0, b_rd_data = '0, mm_a_data, mm_b_data;
    logic [MW-1:0]  mm_a_row;
    logic [KW-1:0]  mm_a_col, mm_b_row;
    logic [NW-1:0]  mm_b_col;
    logic [DW-1:0]  mm_c_data = '0;
    logic [MW-1:0]  mm_c_row = '0;
    logic [NW-1:0]  mm_c_col = '0;
    logic           mm_c_valid = 1'b0, mm_done = 1'b0;
    logic [CAW-1:0] c_wr_addr;
    logic [DW-1:0]  c_wr_data;
    state_t         dbg_state;

    logic [DW-1:0] a_mem[M*K];
    logic [DW-1:0] b_mem[K*N];
    logic [DW-1:0] c_mem[M*N];
    logic [DW-1:0] cap_a[M*K];
    logic [DW-1:0] cap_b[K*N];
    logic [DW-1:0] c_calc[M*N];
    logic [DW-1:0] exp_c[M*N] = '{16'h0400, 16'h0500, 16'h0A00, 16'h0B00,
                                  16'h1000, 16'h1100, 16'h0300, 16'h0200};
    int a_int[M*K] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 0, 2};
    int b_int[K*N] = '{1, 0, 0, 1, 1, 1};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    matmul_seq_driver #(.DATA_WIDTH(DW), .M(M), .N(N), .K(K)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .err(err),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .mm_start(mm_start),
        .mm_a_data(mm_a_data), .mm_a_row(mm_a_row), .mm_a_col(mm_a_col), .mm_a_valid(mm_a_valid),
        .mm_b_data(mm_b_data), .mm_b_row(mm_b_row), .mm_b_col(mm_b_col), .mm_b_valid(mm_b_valid),
        .mm_c_data(mm_c_data), .mm_c_row(mm_c_row), .mm_c_col(mm_c_col),
        .mm_c_valid(mm_c_valid), .mm_done(mm_done),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .dbg_state(dbg_state)
    );

    // Synchronous-read operand RAMs and result RAM
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
        if (c_wr_en) c_mem[c_wr_addr] <= c_wr_data;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Accepted on the next rising edge (T); returns in cycle T+1.
    task automatic send_cmd();
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
        total++; if (mm_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %0b want 0", mm_start); end
        total++; if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %0b%0b want 00", a_rd_en, b_rd_en); end
        total++; if (mm_a_valid !== 1'b0 || mm_b_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b%0b want 00", mm_a_valid, mm_b_valid); end
        total++; if (c_wr_en !== 1'b0 || c_wr_data !== 16'h0 || c_wr_addr !== 3'd0) begin bad++; $display("FAIL rst_cwr: got en=%0b addr=%0d data=%h want 0", c_wr_en, c_wr_addr, c_wr_data); end
        total++; if (a_rd_addr !== 4'd0 || b_rd_addr !== 3'd0) begin bad++; $display("FAIL rst_addr: got %0d/%0d want 0/0", a_rd_addr, b_rd_addr); end
        rst_n = 1'b1;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
        // A result beat while IDLE must not reach the result RAM
        mm_c_valid = 1'b1; mm_c_row = 2'd1; mm_c_col = 1'b1; mm_c_data = 16'h1234;
        tick();
        mm_c_valid = 1'b0;
        total++; if (c_wr_en !== 1'b0) begin bad++; $display("FAIL idle_c_ignored: got %0b want 0", c_wr_en); end
        tick();
    endtask

    task automatic test_timing();
        logic exp_av, exp_bv;
        for (int i = 0; i < M*K; i++) a_mem[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < K*N; i++) b_mem[i] = 16'h2000 + 16'(i);
        send_cmd();
        for (int k = 1; k <= 20; k++) begin
            exp_av = (k >= 3 && k <= 14);
            exp_bv = (k >= 3 && k <= 8);
            total++; if (mm_start !== (k == 1)) begin bad++; $display("FAIL tim_start k=%0d: got %0b want %0b", k, mm_start, k == 1); end
            total++; if (a_rd_en !== (k >= 2 && k <= 13)) begin bad++; $display("FAIL tim_a_rd_en k=%0d: got %0b", k, a_rd_en); end
            total++; if (b_rd_en !== (k >= 2 && k <= 7)) begin bad++; $display("FAIL tim_b_rd_en k=%0d: got %0b", k, b_rd_en); end
            if (k >= 2 && k <= 13) begin
                total++; if (a_rd_addr !== AAW'(k - 2)) begin bad++; $display("FAIL tim_a_addr k=%0d: got %0d want %0d", k, a_rd_addr, k - 2); end
            end
            if (k >= 2 && k <= 7) begin
                total++; if (b_rd_addr !== BAW'(k - 2)) begin bad++; $display("FAIL tim_b_addr k=%0d: got %0d want %0d", k, b_rd_addr, k - 2); end
            end
            total++; if (mm_a_valid !== exp_av) begin bad++; $display("FAIL tim_a_valid k=%0d: got %0b want %0b", k, mm_a_valid, exp_av); end
            total++; if (mm_b_valid !== exp_bv) begin bad++; $display("FAIL tim_b_valid k=%0d: got %0b want %0b", k, mm_b_valid, exp_bv); end
            if (exp_av) begin
                total++;
                if (mm_a_row !== MW'((k - 3) / K) || mm_a_col !== KW'((k - 3) % K) || mm_a_data !== a_mem[k - 3]) begin
                    bad++; $display("FAIL tim_a_tag k=%0d: got (%0d,%0d) %h want (%0d,%0d) %h", k, mm_a_row, mm_a_col, mm_a_data, (k - 3) / K, (k - 3) % K, a_mem[k - 3]);
                end
            end
            if (exp_bv) begin
                total++;
                if (mm_b_row !== KW'((k - 3) / N) || mm_b_col !== NW'((k - 3) % N) || mm_b_data !== b_mem[k - 3]) begin
                    bad++; $display("FAIL tim_b_tag k=%0d: got (%0d,%0d) %h want (%0d,%0d) %h", k, mm_b_row, mm_b_col, mm_b_data, (k - 3) / N, (k - 3) % N, b_mem[k - 3]);
                end
            end
            total++; if (done !== (k == 17)) begin bad++; $display("FAIL tim_done k=%0d: got %0b want %0b", k, done, k == 17); end
            total++; if (busy !== (k <= 17)) begin bad++; $display("FAIL tim_busy k=%0d: got %0b want %0b", k, busy, k <= 17); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL tim_err k=%0d: got %0b want 0", k, err); end
            // First WAIT_DONE cycle is T+16
            mm_done = (k == 16);
            tick();
        end
        mm_done = 1'b0;
    endtask

    task automatic test_integer();
        logic signed [31:0] acc;
        int dones;
        dones = 0;
        for (int i = 0; i < M*K; i++) a_mem[i] = 16'(a_int[i] * 256);
        for (int i = 0; i < K*N; i++) b_mem[i] = 16'(b_int[i] * 256);
        for (int i = 0; i < M*N; i++) c_mem[i] = 16'hDEAD;
        send_cmd();
        for (int k = 1; k <= 26; k++) begin
            if (mm_a_valid) cap_a[int'(mm_a_row) * K + int'(mm_a_col)] = mm_a_data;
            if (mm_b_valid) cap_b[int'(mm_b_row) * N + int'(mm_b_col)] = mm_b_data;
            if (done) dones++;
            if (k == 16) begin
                for (int r = 0; r < M; r++) begin
                    for (int c = 0; c < N; c++) begin
                        acc = '0;
                        for (int kk = 0; kk < K; kk++)
                            acc = acc + 32'($signed(cap_a[r*K + kk])) * 32'($signed(cap_b[kk*N + c]));
                        c_calc[r*N + c] = 16'(acc >>> 8);
                    end
                end
            end
            if (k >= 16 && k <= 23) begin
                mm_c_valid = 1'b1;
                mm_c_row   = MW'((k - 16) / N);
                mm_c_col   = NW'((k - 16) % N);
                mm_c_data  = c_calc[k - 16];
                mm_done    = (k == 23);
            end else begin
                mm_c_valid = 1'b0;
                mm_done    = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < M*N; i++) begin
            total++; if (c_mem[i] !== exp_c[i]) begin bad++; $display("FAIL int_c[%0d]: got %h want %h", i, c_mem[i], exp_c[i]); end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL int_done_count: got %0d want 1", dones); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL int_err: got %0b want 0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL int_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_stub_coincident();
        send_cmd();
        for (int k = 1; k <= 19; k++) begin
            if (k == 17) begin
                total++; if (c_wr_en !== 1'b1 || c_wr_addr !== 3'd5 || c_wr_data !== 16'hFE80) begin
                    bad++; $display("FAIL stub_cwr: got en=%0b addr=%0d data=%h want 1/5/fe80", c_wr_en, c_wr_addr, c_wr_data);
                end
                total++; if (done !== 1'b1) begin bad++; $display("FAIL stub_done: got %0b want 1", done); end
            end else begin
                total++; if (c_wr_en !== 1'b0) begin bad++; $display("FAIL stub_no_cwr k=%0d: got %0b want 0", k, c_wr_en); end
            end
            mm_c_valid = (k == 16);
            mm_done    = (k == 16);
            mm_c_row   = 2'd2;
            mm_c_col   = 1'b1;
            mm_c_data  = 16'hFE80;
            tick();
        end
        mm_c_valid = 1'b0;
        mm_done    = 1'b0;
        total++; if (c_mem[5] !== 16'hFE80) begin bad++; $display("FAIL stub_cmem5: got %h want fe80", c_mem[5]); end
    endtask

    task automatic test_early_done();
        send_cmd();
        for (int k = 1; k <= 18; k++) begin
            total++; if (err !== (k >= 6)) begin bad++; $display("FAIL early_err k=%0d: got %0b want %0b", k, err, k >= 6); end
            total++; if (done !== (k == 17)) begin bad++; $display("FAIL early_done k=%0d: got %0b want %0b", k, done, k == 17); end
            mm_done = (k == 5 || k == 16);
            tick();
        end
        mm_done = 1'b0;
        tick();
        // New command clears err; then an mm_done in the DRAIN cycle sets it again
        send_cmd();
        for (int k = 1; k <= 19; k++) begin
            total++; if (err !== (k >= 16)) begin bad++; $display("FAIL drain_err k=%0d: got %0b want %0b", k, err, k >= 16); end
            total++; if (done !== (k == 18)) begin bad++; $display("FAIL drain_done k=%0d: got %0b want %0b", k, done, k == 18); end
            mm_done = (k == 15 || k == 17);
            tick();
        end
        mm_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        send_cmd();
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        total++; if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0 || mm_start !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: got rd=%0b%0b start=%0b want 0", a_rd_en, b_rd_en, mm_start); end
        total++; if (mm_a_valid !== 1'b0 || mm_b_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b%0b want 00", mm_a_valid, mm_b_valid); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_status: got busy=%0b done=%0b ready=%0b want 0", busy, done, cmd_ready); end
        total++; if (c_wr_en !== 1'b0 || c_wr_data !== 16'h0) begin bad++; $display("FAIL mid_rst_cwr: got %0b %h want 0 0000", c_wr_en, c_wr_data); end
        total++; if (a_rd_addr !== 4'd0 || mm_a_row !== 2'd0 || mm_a_col !== 2'd0) begin bad++; $display("FAIL mid_rst_idx: got %0d (%0d,%0d) want 0", a_rd_addr, mm_a_row, mm_a_col); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dones++;
        end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_release: got ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
        total++; if (dones != 0) begin bad++; $display("FAIL mid_rst_no_done: got %0d want 0", dones); end
        test_integer();
    endtask

    task automatic test_back_to_back();
        int starts, dones;
        starts = 0;
        dones  = 0;
        cmd_valid = 1'b1;
        tick();
        for (int k = 1; k <= 38; k++) begin
            if (mm_start) starts++;
            if (done) dones++;
            total++; if (mm_start !== (k == 1 || k == 19)) begin bad++; $display("FAIL b2b_start k=%0d: got %0b", k, mm_start); end
            total++; if (cmd_ready !== (k == 18 || k >= 36)) begin bad++; $display("FAIL b2b_ready k=%0d: got %0b", k, cmd_ready); end
            mm_done = (k == 16 || k == 34);
            if (k == 35) cmd_valid = 1'b0;
            tick();
        end
        mm_done = 1'b0;
        total++; if (starts != 2) begin bad++; $display("FAIL b2b_start_count: got %0d want 2", starts); end
        total++; if (dones != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    initial begin
        test_reset();
        test_timing();
        tick();
        test_integer();
        test_stub_coincident();
        test_early_done();
        tick();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_seq_driver.md
# matmul_seq_driver

Command-driven sequencer that sits on the other side of `matrix_mult`'s element-stream interface. On one command it pulses `start` into `matrix_mult` and streams operand matrices A (M×K) and B (K×N) from two synchronous-read operand RAMs as row/col-tagged elements. It then captures the tagged C (M×N) result stream into a result RAM and reports completion. It replaces the bench-style loader with synthesizable control for the transformer datapath.

## Interface
- `DATA_WIDTH`, 16: element width (Q8.8 signed, not interpreted here)
- `M`, 4: rows of A and C
- `N`, 2: cols of B and C
- `K`, 3: cols of A / rows of B
- Index widths: `MW=max(1,$clog2(M))`, `NW=max(1,$clog2(N))`, `KW=max(1,$clog2(K))`; RAM address widths `AAW=max(1,$clog2(M*K))`, `BAW=max(1,$clog2(K*N))`, `CAW=max(1,$clog2(M*N))`

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake
- `busy` out 1, `done` out 1 (1-cycle pulse), `err` out 1 (sticky)
- `a_rd_en` out 1, `a_rd_addr` out AAW, `a_rd_data` in DATA_WIDTH: A RAM, row-major, data valid the cycle after `a_rd_en`
- `b_rd_en` out 1, `b_rd_addr` out BAW, `b_rd_data` in DATA_WIDTH: B RAM, same timing
- `mm_start` out 1
- `mm_a_data` out DATA_WIDTH, `mm_a_row` out MW, `mm_a_col` out KW, `mm_a_valid` out 1
- `mm_b_data` out DATA_WIDTH, `mm_b_row` out KW, `mm_b_col` out NW, `mm_b_valid` out 1
- `mm_c_data` in DATA_WIDTH, `mm_c_row` in MW, `mm_c_col` in NW, `mm_c_valid` in 1, `mm_done` in 1
- `c_wr_en` out 1, `c_wr_addr` out CAW, `c_wr_data` out DATA_WIDTH: result RAM write port

## Operation
- States: IDLE → START → STREAM → DRAIN → WAIT_DONE → FIN → IDLE.
- IDLE: `cmd_ready=1`. On `cmd_valid&cmd_ready`, clear `err` and go to START.
- START: `mm_start=1` for exactly one cycle, then go to STREAM.
- STREAM: A and B issue reads independently, one per cycle, starting at address 0. Address = row*cols+col. Col wraps at K−1 (A) or N−1 (B), then row increments. A stops after M*K reads and B after K*N reads. Leave STREAM when both issue counters are finished.
- DRAIN: one cycle for the final read data to emit, then go to WAIT_DONE.
- `mm_*_valid`, `mm_*_row` and `mm_*_col` are the rd_en/row/col values registered one cycle. `mm_*_data` is wired directly from `*_rd_data`.
- Result capture is active in START through FIN. Each `mm_c_valid` produces, one cycle later, `c_wr_en=1`, `c_wr_addr=row*N+col` and `c_wr_data=mm_c_data`. `mm_c_valid` is ignored in IDLE.
- WAIT_DONE: on `mm_done`, go to FIN. A `mm_c_valid` in the same cycle as `mm_done` is still written, and that write lands in the FIN cycle.
- FIN: `done=1` for one cycle, then go to IDLE.
- `mm_done` seen in START, STREAM or DRAIN sets `err`. Sequencing continues regardless.
- `busy=1` in every state except IDLE.

## Timing
- Command accepted at edge T. Then: `mm_start` high in T+1; first `a_rd_en`/`b_rd_en` in T+2; first `mm_a_valid`/`mm_b_valid` in T+3.
- Last `mm_a_valid` is in T+2+M*K. Last `mm_b_valid` is in T+2+K*N.
- The DRAIN exit edge is T+3+max(M*K, K*N).
- Streams are gap-free; no backpressure from `matrix_mult`.
- Reset values: all control outputs and `err` are 0, state is IDLE, `cmd_ready=1` from the first cycle after reset. Addresses, rows and cols reset to 0; `c_wr_data` resets to 0.
- Reset asserted mid-operation returns the block to IDLE on the next edge. No partial `done` is produced.
- `cmd_valid` outside IDLE is ignored; no queueing.

## Structure
- Package `matmul_pkg` holds the state encoding localparams, the `max1clog2` width function and a shared index-width helper. `matrix_mult` also uses this package.
- Sub-module `mat_index_counter` (parameters ROWS, COLS): enable in; row, col, linear address and `last` out; synchronous clear.
  - Instantiated twice: A (M,K) and B (K,N).
  - The C address is computed combinationally from the tags.

## Test plan
- Integer case: A=[[1,2,3],[4,5,6],[7,8,9],[1,0,2]] (0x0100=1.0), B=[[1,0],[0,1],[1,1]], through real `matrix_mult` → C RAM holds 0x0400, 0x0500, 0x0A00, 0x0B00, 0x1000, 0x1100, 0x0300, 0x0200; `done` pulses once; `err=0`.
- Cycle check: cmd at T → `mm_start` in T+1; 12 consecutive A valids T+3..T+14 with (row,col) (0,0),(0,1),(0,2),(1,0)…(3,2); 6 B valids T+3..T+8.
- Stub responder: `mm_c_valid` for (2,1), data 0xFE80, coincident with `mm_done` → `c_wr_en` at addr 5 with 0xFE80 in the FIN cycle, `done` in the same cycle.
- Early `mm_done` pulsed during STREAM → `err=1` and stays 1 through FIN. Next accepted command clears it.
- Reset asserted during STREAM → all outputs 0 on the next edge and `cmd_ready=1` once reset is released. A fresh command then gives correct results.
- `cmd_valid` held high during the run → exactly one run per IDLE acceptance; back-to-back commands show a one-cycle `cmd_ready` window after FIN.
